cycle_timer_arbiter: RTL and testbench

Shares one cycle-measurement counter among `NUM_REQ` requesters. The block grants the counter to one requester at a time in round-robin order and counts clock cycles until that requester signals done. It then presents the result (requester id and count) on a valid/ready result port. It sits between the operation units and the measurement/readout logic.

---
 rtl/cycle_timer_pkg.sv | 36 +++
 rtl/cycle_timer_arbiter_run_counter.sv | 28 ++
 rtl/cycle_timer_arbiter.sv | 105 ++++++++++
 tb/tb_cycle_timer_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cycle_timer_pkg.sv
// Shared types, defaults and the round-robin pick helper for cycle_timer_arbiter.
package cycle_timer_pkg;

  localparam int unsigned DefaultNumReq    = 4;
  localparam int unsigned DefaultCountBits = 10;
  // Upper bound on requesters handled by rr_pick.
  localparam int unsigned MaxReq           = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReport
  } state_e;

  // First set bit of req at or after ptr, wrapping within num_req; 0 if none set.
  function automatic int unsigned rr_pick(logic [MaxReq-1:0] req, int unsigned num_req,
                                          int unsigned ptr);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < num_req) begin
        idx = ptr + i;
        if (idx >= num_req) idx = idx - num_req;
        if (!found && req[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cycle_timer_arbiter_run_counter.sv
// Clearable cycle counter with an all-ones flag used for saturation detection.
module run_counter #(
  parameter int unsigned COUNT_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  output logic [COUNT_BITS-1:0] count,
  output logic                  at_max
);

  logic [COUNT_BITS-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + COUNT_BITS'(1);
    end
  end

  assign count  = count_q;
  assign at_max = &count_q;

endmodule

// File: rtl/cycle_timer_arbiter.sv
// Round-robin sharing of one cycle counter among requesters, result on valid/ready.
// Optional saturation timeout enabled by defining CYCLE_TIMER_TIMEOUT_EN.
module cycle_timer_arbiter
  import cycle_timer_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefaultNumReq,
  parameter int unsigned COUNT_BITS = DefaultCountBits,
  parameter int unsigned ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    done,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ID_BITS-1:0]    result_id,
  output logic [COUNT_BITS-1:0] result_count,
  output logic                  result_timeout,
  output logic                  busy
);

`ifdef CYCLE_TIMER_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  state_e                state_q;
  logic [ID_BITS-1:0]    rr_ptr_q;
  logic [ID_BITS-1:0]    grant_id_q;
  logic [ID_BITS-1:0]    result_id_q;
  logic [COUNT_BITS-1:0] result_count_q;
  logic                  result_timeout_q;

  logic [MaxReq-1:0]     req_ext;
  logic [ID_BITS-1:0]    pick_id;
  logic [ID_BITS-1:0]    next_ptr;
  logic                  grant;
  logic                  done_sel;
  logic                  sat_stop;
  logic [COUNT_BITS-1:0] count;
  logic                  at_max;

  assign req_ext  = MaxReq'(req_valid);
  assign pick_id  = ID_BITS'(rr_pick(req_ext, NUM_REQ, 32'(rr_ptr_q)));
  assign next_ptr = (pick_id == ID_BITS'(NUM_REQ - 1)) ? '0 : pick_id + ID_BITS'(1);
  assign grant    = (state_q == StIdle) && (|req_valid);
  assign done_sel = done[grant_id_q];
  // Done in the saturating cycle takes priority over timeout.
  assign sat_stop = TimeoutEn && at_max && !done_sel;

  assign req_ready = grant ? (NUM_REQ'(1) << pick_id) : '0;

  run_counter #(
    .COUNT_BITS(COUNT_BITS)
  ) u_run_counter (
    .clock (clock),
    .reset (reset),
    .clear (grant),
    .enable((state_q == StRun) && !done_sel),
    .count (count),
    .at_max(at_max)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      rr_ptr_q         <= '0;
      grant_id_q       <= '0;
      result_id_q      <= '0;
      result_count_q   <= '0;
      result_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            grant_id_q <= pick_id;
            rr_ptr_q   <= next_ptr;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (done_sel || sat_stop) begin
            result_id_q      <= grant_id_q;
            result_count_q   <= count;
            result_timeout_q <= sat_stop;
            state_q          <= StReport;
          end
        end
        StReport: begin
          if (result_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_valid   = (state_q == StReport);
  assign busy           = (state_q != StIdle);
  assign result_id      = result_id_q;
  assign result_count   = result_count_q;
  assign result_timeout = result_timeout_q;

endmodule

// File: tb/tb_cycle_timer_arbiter.sv
// Directed self-checking bench for cycle_timer_arbiter (NUM_REQ=4, COUNT_BITS=4).
module tb_cycle_timer_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CB = 4;
  localparam int unsigned IB = 2;

  logic          clock;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] done;
  logic          result_valid;
  logic          result_ready;
  logic [IB-1:0] result_id;
  logic [CB-1:0] result_count;
  logic          result_timeout;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_timer_arbiter #(
    .NUM_REQ   (NR),
    .COUNT_BITS(CB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .done          (done),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_id     (result_id),
    .result_count  (result_count),
    .result_timeout(result_timeout),
    .busy          (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From IDLE: offer reqs, expect grant to exp_id, done after k RUN cycles
  // (done driven with noise before that), then check the reported result.
  task automatic run_to_report(input logic [NR-1:0] reqs, input int exp_id, input int k,
                               input logic [NR-1:0] noise);
    req_valid = reqs;
    #1;
    check_eq("grant", 32'(req_ready), 32'(1 << exp_id));
    tick();
    check_eq("run_ready0", 32'(req_ready), 0);
    check_eq("run_busy", 32'(busy), 1);
    for (int i = 0; i < k; i++) begin
      done = noise;
      tick();
    end
    done = noise | NR'(1 << exp_id);
    #1;
    check_eq("pre_valid", 32'(result_valid), 0);
    tick();
    done = '0;
    check_eq("res_valid", 32'(result_valid), 1);
    check_eq("res_id", 32'(result_id), 32'(exp_id));
    check_eq("res_count", 32'(result_count), 32'(k));
    check_eq("res_timeout", 32'(result_timeout), 0);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_eq("idle_valid", 32'(result_valid), 0);
  endtask

  logic seen;

  initial begin
    reset        = 1'b0;
    req_valid    = '0;
    done         = '0;
    result_ready = 1'b0;
    #3;
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_valid", 32'(result_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_count", 32'(result_count), 0);
    tick();
    reset = 1'b1;
    tick();

    // Single run
    run_to_report(4'b0001, 0, 5, 4'b0000);
    req_valid = '0;
    handshake();
    check_eq("keep_count", 32'(result_count), 5);
    check_eq("idle_busy", 32'(busy), 0);

    // Round-robin from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int r = 0; r < 5; r++) begin
      run_to_report(4'b1111, r % 4, 2, 4'b0000);
      handshake();
    end
    req_valid = '0;

    // Zero count (ptr=1), then ignored done[2] while req 1 runs (ptr=2 -> picks 1)
    run_to_report(4'b0010, 1, 0, 4'b0000);
    handshake();
    run_to_report(4'b0010, 1, 3, 4'b0100);
    handshake();

    // Backpressure: req 2 runs while req 3 waits (ptr=2)
    run_to_report(4'b1100, 2, 1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_valid", 32'(result_valid), 1);
      check_eq("bp_id", 32'(result_id), 2);
      check_eq("bp_count", 32'(result_count), 1);
      check_eq("bp_ready", 32'(req_ready), 0);
      check_eq("bp_busy", 32'(busy), 1);
    end
    req_valid = 4'b1000;
    handshake();
    #1;
    check_eq("bp_next_grant", 32'(req_ready), 32'b1000);
    run_to_report(4'b1000, 3, 2, 4'b0000);
    handshake();

    // Reset mid-run (ptr=0 after req 3; grant req 1 to move ptr to 2)
    run_to_report(4'b0010, 1, 1, 4'b0000);
    handshake();
    req_valid = 4'b0001;
    #1;
    check_eq("mr_grant", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("mr_busy", 32'(busy), 0);
    check_eq("mr_valid", 32'(result_valid), 0);
    check_eq("mr_id", 32'(result_id), 0);
    check_eq("mr_count", 32'(result_count), 0);
    check_eq("mr_timeout", 32'(result_timeout), 0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("mr_no_result", 32'(result_valid), 0);
    run_to_report(4'b0101, 0, 1, 4'b0000);
    req_valid = '0;
    handshake();

    // Timeout behaviour, done never asserted (ptr=1)
    req_valid = 4'b0010;
    #1;
    check_eq("to_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
`ifdef CYCLE_TIMER_TIMEOUT_EN
    repeat (15) tick();
    check_eq("to_pre", 32'(result_valid), 0);
    tick();
    check_eq("to_valid", 32'(result_valid), 1);
    check_eq("to_count", 32'(result_count), 15);
    check_eq("to_flag", 32'(result_timeout), 1);
    handshake();
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | result_valid;
      tick();
    end
    seen = seen | result_valid;
    check_eq("wrap_no_result", 32'(seen), 0);
    done = 4'b0010;
    tick();
    done = '0;
    check_eq("wrap_valid", 32'(result_valid), 1);
    check_eq("wrap_count", 32'(result_count), 8);
    check_eq("wrap_flag", 32'(result_timeout), 0);
    handshake();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
